// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter: round-robin grant locked for the whole
// bus cycle, with a watchdog that errors out strobes the slave never answers.
module wb_arbiter2 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW-1:0]   m0_dat_w,
  input  logic [DW/8-1:0] m0_sel,
  output logic            m0_ack,
  output logic            m0_err,
  output logic [DW-1:0]   m0_dat_r,
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW-1:0]   m1_dat_w,
  input  logic [DW/8-1:0] m1_sel,
  output logic            m1_ack,
  output logic            m1_err,
  output logic [DW-1:0]   m1_dat_r,
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat_w,
  output logic [DW/8-1:0] s_sel,
  input  logic            s_ack,
  input  logic            s_err,
  input  logic [DW-1:0]   s_dat_r,
  output logic [1:0]      grant
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] G0   = 2'd1;
  localparam logic [1:0] G1   = 2'd2;

  localparam int             WW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0]  WD_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          sel0, sel1;
  logic          silent;
  logic          wdog_err;

  // last_q holds the index of the previous owner; a tie goes to the other one.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc && m1_cyc) state_d = last_q ? G0 : G1;
        else if (m0_cyc)      state_d = G0;
        else if (m1_cyc)      state_d = G1;
      end
      G0: begin
        if (!m0_cyc) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      G1: begin
        if (!m1_cyc) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // grant is the one-hot view of the FSM state.
  always_comb begin
    sel0  = (state_q == G0);
    sel1  = (state_q == G1);
    grant = {sel1, sel0};

    s_cyc   = (sel0 & m0_cyc) | (sel1 & m1_cyc);
    s_stb   = (sel0 & m0_stb) | (sel1 & m1_stb);
    s_we    = (sel0 & m0_we)  | (sel1 & m1_we);
    s_adr   = sel0 ? m0_adr   : (sel1 ? m1_adr   : '0);
    s_dat_w = sel0 ? m0_dat_w : (sel1 ? m1_dat_w : '0);
    s_sel   = sel0 ? m0_sel   : (sel1 ? m1_sel   : '0);

    // An ack in the timeout cycle suppresses the watchdog error.
    silent   = s_stb & ~s_ack & ~s_err;
    wdog_err = (TIMEOUT > 0) && silent && (wdog_q == WD_LAST);

    m0_ack   = sel0 & m0_stb & s_ack;
    m0_err   = sel0 & m0_stb & (s_err | wdog_err);
    m0_dat_r = sel0 ? s_dat_r : '0;
    m1_ack   = sel1 & m1_stb & s_ack;
    m1_err   = sel1 & m1_stb & (s_err | wdog_err);
    m1_dat_r = sel1 ? s_dat_r : '0;

    if ((TIMEOUT == 0) || (state_d != state_q) || !silent || wdog_err) wdog_d = '0;
    else                                                               wdog_d = wdog_q + WW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule
